// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : iterative MIPS multiply/divide unit owning the HI/LO pair.
// Optional macro MDU_DIVZERO_FLAG_EN adds a DivZero status output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
`ifdef MDU_DIVZERO_FLAG_EN
  ,
  output logic             DivZero
`endif
);

  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MTHI  = 3'b100;
  localparam logic [2:0] c_OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // exactly its unsigned magnitude.
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  assign w_signed = ~Op[0];
  assign w_sa     = w_signed & BusA[WIDTH-1];
  assign w_sb     = w_signed & BusB[WIDTH-1];
  assign w_mag_a  = w_sa ? -BusA : BusA;
  assign w_mag_b  = w_sb ? -BusB : BusB;

  // Multiply step: r_acc = {partial product, remaining multiplier bits}.
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;

  assign w_addend = r_acc[0] ? r_b : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

  // Restoring divide step: r_acc low half shifts dividend out, quotient in.
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_borrow;

  assign w_shift  = {r_rem, r_acc[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_b};
  assign w_borrow = w_diff[WIDTH];

  logic               w_neg;
  logic               w_divzero;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_neg      = r_sign_a ^ r_sign_b;
  assign w_divzero  = (r_b == '0);
  assign w_prod_fix = w_neg ? -r_acc : r_acc;
  assign w_quo_fix  = w_divzero ? '1 :
                      (w_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem_fix  = r_sign_a ? -r_rem : r_rem;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
`ifdef MDU_DIVZERO_FLAG_EN
      DivZero  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            case (Op)
              c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
                r_state  <= S_RUN;
                r_cnt    <= CNT_W'(WIDTH);
                Busy     <= 1'b1;
                r_is_div <= Op[1];
                r_sign_a <= w_sa;
                r_sign_b <= w_sb;
                r_rem    <= '0;
                if (Op[1]) begin
                  r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                  r_b   <= w_mag_b;
                end else begin
                  r_acc <= {{WIDTH{1'b0}}, w_mag_b};
                  r_b   <= w_mag_a;
                end
`ifdef MDU_DIVZERO_FLAG_EN
                DivZero <= 1'b0;
`endif
              end
              c_OP_MTHI: begin
                Hi <= BusA;
`ifdef MDU_DIVZERO_FLAG_EN
                DivZero <= 1'b0;
`endif
              end
              c_OP_MTLO: begin
                Lo <= BusA;
`ifdef MDU_DIVZERO_FLAG_EN
                DivZero <= 1'b0;
`endif
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_is_div) begin
            r_rem              <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], ~w_borrow};
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          end
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            Hi <= w_rem_fix;
            Lo <= w_quo_fix;
          end else begin
            Hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            Lo <= w_prod_fix[WIDTH-1:0];
          end
`ifdef MDU_DIVZERO_FLAG_EN
          DivZero <= r_is_div & w_divzero;
`endif
          Done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
